// File: rtl/psychic5_sdram_responder.sv
// Psychic 5 SDRAM read responder: arbitrates main CPU and object ROM byte reads.
// Optional per-channel word cache enabled by defining PSYCHIC5_SDRAM_WORDCACHE_EN.
module psychic5_sdram_responder #(
  parameter logic [21:0] MAINCPU_BASE = 22'h000000,
  parameter logic [21:0] OBJROM_BASE  = 22'h010000,
  parameter bit          OBJ_PRIORITY = 1'b1
) (
  input  logic        i_EMU_MCLK,
  input  logic        i_EMU_RST,
  input  logic [16:0] i_EMU_MAINCPU_ADDR,
  input  logic        i_EMU_MAINCPU_RQ_n,
  output logic [7:0]  o_EMU_MAINCPU_DATA,
  output logic        o_EMU_MAINCPU_PEND,
  input  logic [16:0] i_EMU_OBJROM_ADDR,
  input  logic        i_EMU_OBJROM_RQ_n,
  output logic [7:0]  o_EMU_OBJROM_DATA,
  output logic        o_EMU_OBJROM_PEND,
  output logic        o_SDRAM_RQ,
  output logic [21:0] o_SDRAM_ADDR,
  input  logic        i_SDRAM_ACK,
  input  logic [15:0] i_SDRAM_DOUT
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t           state_q, state_d;
  logic [1:0][16:0] ch_addr, req_addr, last_addr, cmp_addr;
  logic [1:0][7:0]  data_q;
  logic [1:0]       ch_rqn, rqn_q, pend, renew;
  logic [1:0]       is_new, inflight, granting, capture, hit;
  logic             sel_q, sel_d, grant, last_prio_q;
  logic             ack_now, sdram_rq_q;
  logic [21:0]      sdram_addr_q, gnt_addr;
  logic [7:0]       ack_byte;

  assign ch_addr = {i_EMU_OBJROM_ADDR, i_EMU_MAINCPU_ADDR};
  assign ch_rqn  = {i_EMU_OBJROM_RQ_n, i_EMU_MAINCPU_RQ_n};
  assign ack_now = (state_q == S_WAIT) && i_SDRAM_ACK;

  // last_addr of the in-flight channel already holds the served address
  assign ack_byte = last_addr[sel_q][0] ? i_SDRAM_DOUT[15:8]
                                        : i_SDRAM_DOUT[7:0];

  assign gnt_addr = (sel_d ? OBJROM_BASE : MAINCPU_BASE)
                  + {6'b0, req_addr[sel_d][16:1]};

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    grant   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|pend) begin
          grant   = 1'b1;
          state_d = S_WAIT;
          if (&pend)
            sel_d = last_prio_q ? ~OBJ_PRIORITY : OBJ_PRIORITY;
          else
            sel_d = pend[1];
        end
      end
      S_WAIT: begin
        if (i_SDRAM_ACK) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      inflight[i] = (state_q == S_WAIT) && (sel_q == 1'(i));
      granting[i] = grant && (sel_d == 1'(i));
      cmp_addr[i] = granting[i] ? req_addr[i] : last_addr[i];
      is_new[i]   = !ch_rqn[i]
                  && (rqn_q[i] || (ch_addr[i] != cmp_addr[i]));
      capture[i]  = !ch_rqn[i]
                  && (is_new[i] || (pend[i] && !inflight[i]));
    end
  end

`ifdef PSYCHIC5_SDRAM_WORDCACHE_EN
  logic [1:0]       c_valid;
  logic [1:0][15:0] c_waddr, c_word;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      hit[i] = is_new[i] && !inflight[i] && !granting[i]
             && c_valid[i] && (ch_addr[i][16:1] == c_waddr[i]);
    end
  end

  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_RST) begin
      c_valid <= '0;
      c_waddr <= '0;
      c_word  <= '0;
    end else if (ack_now) begin
      c_valid[sel_q] <= 1'b1;
      c_waddr[sel_q] <= last_addr[sel_q][16:1];
      c_word[sel_q]  <= i_SDRAM_DOUT;
    end
  end
`else
  assign hit = '0;
`endif

  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_RST) begin
      state_q      <= S_IDLE;
      sel_q        <= 1'b0;
      last_prio_q  <= 1'b0;
      sdram_rq_q   <= 1'b0;
      sdram_addr_q <= '0;
      rqn_q        <= '1;
      pend         <= '0;
      renew        <= '0;
      data_q       <= '0;
      req_addr     <= '0;
      last_addr    <= {17'h1FFFF, 17'h1FFFF};
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rqn_q   <= ch_rqn;
      if (grant) begin
        sdram_rq_q       <= 1'b1;
        sdram_addr_q     <= gnt_addr;
        last_addr[sel_d] <= req_addr[sel_d];
        last_prio_q      <= (sel_d == OBJ_PRIORITY);
      end
      if (ack_now) sdram_rq_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (capture[i]) req_addr[i] <= ch_addr[i];
        if (is_new[i]) pend[i] <= 1'b1;
        // a fresh request arriving while this channel is being served
        if (is_new[i] && (inflight[i] || granting[i]))
          renew[i] <= 1'b1;
        if (ack_now && inflight[i]) begin
          data_q[i] <= ack_byte;
          pend[i]   <= renew[i] | is_new[i];
          renew[i]  <= 1'b0;
        end
`ifdef PSYCHIC5_SDRAM_WORDCACHE_EN
        if (hit[i]) begin
          data_q[i]    <= ch_addr[i][0] ? c_word[i][15:8]
                                        : c_word[i][7:0];
          pend[i]      <= 1'b0;
          last_addr[i] <= ch_addr[i];
        end
`endif
      end
    end
  end

  assign o_EMU_MAINCPU_DATA = data_q[0];
  assign o_EMU_OBJROM_DATA  = data_q[1];
  assign o_EMU_MAINCPU_PEND = pend[0];
  assign o_EMU_OBJROM_PEND  = pend[1];
  assign o_SDRAM_RQ         = sdram_rq_q;
  assign o_SDRAM_ADDR       = sdram_addr_q;

endmodule

// File: tb/tb_psychic5_sdram_responder.sv
// Scoreboard bench for psychic5_sdram_responder: random reads against a
// behavioural model of arbitration, fairness and byte selection.
module tb_psychic5_sdram_responder;

`ifdef PSYCHIC5_SDRAM_WORDCACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  localparam logic [21:0] MAINB = 22'h000000;
  localparam logic [21:0] OBJB  = 22'h010000;

  typedef struct {
    bit          ch;
    logic [21:0] addr;
    logic [7:0]  byt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] m_addr, o_addr;
  logic        m_rqn, o_rqn;
  logic [7:0]  m_data, o_data;
  logic        m_pend, o_pend;
  logic        sd_rq, sd_ack;
  logic [21:0] sd_addr;
  logic [15:0] sd_dout;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  bit   auto_ack = 1'b0;
  bit   ign_ack  = 1'b0;
  bit   m_last_prio = 1'b0;
  logic [15:0] lw_m = 16'hFFFF;
  logic [15:0] lw_o = 16'hFFFF;

  psychic5_sdram_responder dut (
    .i_EMU_MCLK         (clk),
    .i_EMU_RST          (rst),
    .i_EMU_MAINCPU_ADDR (m_addr),
    .i_EMU_MAINCPU_RQ_n (m_rqn),
    .o_EMU_MAINCPU_DATA (m_data),
    .o_EMU_MAINCPU_PEND (m_pend),
    .i_EMU_OBJROM_ADDR  (o_addr),
    .i_EMU_OBJROM_RQ_n  (o_rqn),
    .o_EMU_OBJROM_DATA  (o_data),
    .o_EMU_OBJROM_PEND  (o_pend),
    .o_SDRAM_RQ         (sd_rq),
    .o_SDRAM_ADDR       (sd_addr),
    .i_SDRAM_ACK        (sd_ack),
    .i_SDRAM_DOUT       (sd_dout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] memw(input logic [21:0] a);
    logic [15:0] t;
    t = a[15:0] * 16'h9E37;
    return t ^ {10'b0, a[21:16]} ^ 16'h5AA5;
  endfunction

  function automatic exp_t mk(input bit ch, input logic [16:0] a,
                              input logic [15:0] w);
    exp_t e;
    e.ch   = ch;
    e.addr = (ch ? OBJB : MAINB) + {6'b0, a[16:1]};
    e.byt  = a[0] ? w[15:8] : w[7:0];
    return e;
  endfunction

  function automatic exp_t mk_auto(input bit ch, input logic [16:0] a);
    exp_t e;
    e = mk(ch, a, 16'h0);
    return mk(ch, a, memw(e.addr));
  endfunction

  function automatic logic [16:0] pick(input logic [15:0] avoid);
    logic [16:0] a;
    do a = 17'($urandom);
    while (a[16:1] == avoid || a[16:1] == 16'h0080);
    return a;
  endfunction

  // SDRAM controller model: acknowledges each request after a random delay
  initial begin
    sd_ack  = 1'b0;
    sd_dout = 16'h0;
    forever begin
      tick();
      if (auto_ack && sd_rq) begin
        repeat ($urandom_range(0, 3)) tick();
        sd_dout = memw(sd_addr);
        sd_ack  = 1'b1;
        tick();
        sd_ack  = 1'b0;
      end
    end
  end

  // Monitor: each ACK pops one expectation; DATA is checked a cycle later
  initial begin
    bit   chk_nxt = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_nxt) begin
        chk_nxt = 1'b0;
        chk("data", e.ch ? o_data : m_data, e.byt);
      end
      if (sd_ack && !ign_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sdram_addr", sd_addr, e.addr);
          chk("rq_held", sd_rq, 1);
          chk_nxt = 1'b1;
        end
      end
    end
  end

  task automatic wait_served();
    int n = 0;
    repeat (2) tick();
    while ((m_pend || o_pend || exp_q.size() != 0) && n < 400) begin
      tick();
      n++;
    end
    chk("serve_timeout", n >= 400, 0);
    repeat (2) tick();
  endtask

  task automatic run_txn();
    int          kind;
    logic [16:0] am, ao;
    kind = $urandom_range(0, 2);
    am = pick(lw_m);
    ao = pick(lw_o);
    if (kind == 0) begin
      exp_q.push_back(mk_auto(0, am));
      m_last_prio = 1'b0;
    end else if (kind == 1) begin
      exp_q.push_back(mk_auto(1, ao));
      m_last_prio = 1'b1;
    end else if (m_last_prio) begin
      exp_q.push_back(mk_auto(0, am));
      exp_q.push_back(mk_auto(1, ao));
      m_last_prio = 1'b1;
    end else begin
      exp_q.push_back(mk_auto(1, ao));
      exp_q.push_back(mk_auto(0, am));
      m_last_prio = 1'b0;
    end
    if (kind != 1) begin
      m_addr = am;
      m_rqn  = 1'b0;
      lw_m   = am[16:1];
    end
    if (kind != 0) begin
      o_addr = ao;
      o_rqn  = 1'b0;
      lw_o   = ao[16:1];
    end
    wait_served();
    m_rqn = 1'b1;
    o_rqn = 1'b1;
    tick();
  endtask

  initial begin
    int cnt;
    rst    = 1'b1;
    m_rqn  = 1'b1;
    o_rqn  = 1'b1;
    m_addr = '0;
    o_addr = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_mdata", m_data, 8'h00);
    chk("rst_odata", o_data, 8'h00);
    chk("rst_pend", {m_pend, o_pend}, 2'b00);
    chk("rst_rq", sd_rq, 0);
    chk("rst_addr", sd_addr, 22'h0);

    // reset while a read is outstanding, then a late ACK
    m_addr = 17'h00005;
    m_rqn  = 1'b0;
    repeat (2) tick();
    chk("midwait_rq", sd_rq, 1);
    rst   = 1'b1;
    m_rqn = 1'b1;
    tick();
    rst     = 1'b0;
    ign_ack = 1'b1;
    sd_dout = 16'hFFFF;
    sd_ack  = 1'b1;
    tick();
    sd_ack  = 1'b0;
    ign_ack = 1'b0;
    tick();
    chk("late_ack_mdata", m_data, 8'h00);
    chk("late_ack_odata", o_data, 8'h00);
    chk("late_ack_rq", sd_rq, 0);
    chk("late_ack_pend", {m_pend, o_pend}, 2'b00);

    // main CPU single read, latency and odd byte
    m_addr = 17'h00003;
    m_rqn  = 1'b0;
    tick();
    chk("lat1_rq", sd_rq, 0);
    chk("lat1_pend", m_pend, 1);
    tick();
    chk("lat2_rq", sd_rq, 1);
    chk("lat2_addr", sd_addr, 22'h000001);
    exp_q.push_back(mk(0, 17'h00003, 16'hA55A));
    sd_dout = 16'hA55A;
    sd_ack  = 1'b1;
    tick();
    sd_ack = 1'b0;
    chk("single_data", m_data, 8'hA5);
    chk("single_pend", m_pend, 0);
    chk("single_rq_drop", sd_rq, 0);
    m_rqn = 1'b1;
    lw_m  = 16'h0001;
    tick();

    // simultaneous requests: object wins first
    auto_ack = 1'b1;
    exp_q.push_back(mk_auto(1, 17'h00020));
    exp_q.push_back(mk_auto(0, 17'h00010));
    m_last_prio = 1'b0;
    m_addr = 17'h00010;
    o_addr = 17'h00020;
    m_rqn  = 1'b0;
    o_rqn  = 1'b0;
    wait_served();
    m_rqn = 1'b1;
    o_rqn = 1'b1;
    tick();

    // object re-requests on every ACK; main must get the second grant
    auto_ack = 1'b0;
    exp_q.push_back(mk(1, 17'h00050, 16'hB1C2));
    exp_q.push_back(mk(0, 17'h00041, 16'hD3E4));
    exp_q.push_back(mk(1, 17'h00052, 16'hF5A6));
    m_addr = 17'h00041;
    o_addr = 17'h00050;
    m_rqn  = 1'b0;
    o_rqn  = 1'b0;
    repeat (2) tick();
    chk("starve_g1", sd_addr, 22'h010028);
    sd_dout = 16'hB1C2;
    sd_ack  = 1'b1;
    o_addr  = 17'h00052;
    tick();
    sd_ack = 1'b0;
    tick();
    chk("starve_g2", sd_addr, 22'h000020);
    sd_dout = 16'hD3E4;
    sd_ack  = 1'b1;
    tick();
    sd_ack = 1'b0;
    tick();
    chk("starve_g3", sd_addr, 22'h010029);
    sd_dout = 16'hF5A6;
    sd_ack  = 1'b1;
    tick();
    sd_ack = 1'b0;
    tick();
    chk("starve_pend", {m_pend, o_pend}, 2'b00);
    m_rqn = 1'b1;
    o_rqn = 1'b1;
    m_last_prio = 1'b1;
    lw_m = 16'h0020;
    lw_o = 16'h0029;
    tick();

    // same address held low: no re-read; toggled RQ_n: new read
    auto_ack = 1'b1;
    exp_q.push_back(mk_auto(0, 17'h00060));
    m_last_prio = 1'b0;
    m_addr = 17'h00060;
    m_rqn  = 1'b0;
    wait_served();
    cnt = 0;
    repeat (10) begin
      tick();
      if (sd_rq) cnt++;
    end
    chk("held_no_rq", cnt, 0);
    m_rqn = 1'b1;
    tick();
    if (!CACHE) exp_q.push_back(mk_auto(0, 17'h00060));
    m_rqn = 1'b0;
    cnt = 0;
    repeat (10) begin
      tick();
      if (sd_rq) cnt++;
    end
    chk("toggle_rq", cnt != 0, !CACHE);
    chk("toggle_data", m_data, mk_auto(0, 17'h00060).byt);
    wait_served();
    m_rqn = 1'b1;
    lw_m  = 16'h0030;
    tick();

    repeat (40) run_txn();

`ifdef PSYCHIC5_SDRAM_WORDCACHE_EN
    auto_ack = 1'b0;
    m_addr = 17'h00100;
    m_rqn  = 1'b0;
    repeat (2) tick();
    chk("cache_fill_rq", sd_rq, 1);
    exp_q.push_back(mk(0, 17'h00100, 16'h1234));
    sd_dout = 16'h1234;
    sd_ack  = 1'b1;
    tick();
    sd_ack = 1'b0;
    tick();
    m_rqn = 1'b1;
    tick();
    m_addr = 17'h00101;
    m_rqn  = 1'b0;
    tick();
    chk("cache_hit_data", m_data, 8'h12);
    cnt = 0;
    repeat (6) begin
      if (sd_rq || m_pend) cnt++;
      tick();
    end
    chk("cache_no_rq", cnt, 0);
    m_rqn = 1'b1;
    tick();
`endif

    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
